truth_table_capture: RTL and testbench
======================================

TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, cycles each input vector is held before dut_out is sampled; legal range 1..255, elaboration error outside it.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a full 8-vector capture; accepted only in IDLE.
REQ-005 abort  input  1  cancel a capture in progress.
REQ-006 dut_out  input  1  output of the 3-input logic circuit under characterization.
REQ-007 drv_in1, drv_in2, drv_in3  output  1 each  stimulus to the circuit inputs in1, in2, in3.
REQ-008 busy  output  1  high in DRIVE state.
REQ-009 rule_code  output  8  captured truth table.
REQ-010 rule_valid  output  1  rule_code complete and stable.
REQ-011 rule_ready  input  1  consumer accepts rule_code.

Function
REQ-012 FSM states: IDLE, DRIVE, HOLD.
- IDLE->DRIVE on start.
- DRIVE->HOLD after vector 7 is sampled.
- DRIVE->IDLE on abort.
- HOLD->IDLE when rule_valid && rule_ready.
REQ-013 On start accept: vector index idx=0, rule_code cleared to 0x00, settle counter loaded with SETTLE_CYCLES-1.
REQ-014 In DRIVE, {drv_in1,drv_in2,drv_in3} = idx[2:0], registered; drv_in1 is the MSB.
REQ-015 Each vector is held exactly SETTLE_CYCLES cycles. Settle counter decrements each DRIVE cycle. On the edge where the counter is 0:
- dut_out is written into rule_code[7-idx];
- idx increments;
- counter reloads.
REQ-016 Bit ordering: MSB = row 000, LSB = row 111. Example: a circuit with out=1 only on rows 001, 101, 111 yields rule_code 0x45.
REQ-017 Latency: rule_valid rises exactly 8*SETTLE_CYCLES cycles after the start-accept edge.
REQ-018 In HOLD:
- rule_valid=1, rule_code stable, drv outputs held at 3'b111.
- rule_valid drops the cycle after the rule_valid && rule_ready edge.
REQ-019 start is ignored in DRIVE and HOLD. start coincident with the HOLD handshake edge is ignored; a new start is required in IDLE.
REQ-020 abort in DRIVE:
- next state IDLE; drv outputs 3'b000; rule_valid stays 0; rule_code keeps its partial value.
- abort in IDLE or HOLD has no effect.
- abort has priority over the vector-7 sample in the same cycle.
REQ-021 In IDLE, drv outputs are 3'b000 and rule_code keeps its last value.

Reset
REQ-022 Asserting rst_n low, at any time including mid-capture, immediately forces:
- state IDLE, idx=0, counter=0;
- drv outputs 3'b000;
- busy=0, rule_valid=0, rule_code=0x00.
REQ-023 After rst_n deasserts, the first start is accepted on the first rising edge at which it is sampled high.

Configuration
REQ-024 Macro TTC_SYNC_EN.
- Defined: dut_out passes through a 2-flop synchronizer before sampling, and each vector is held SETTLE_CYCLES+2 cycles. Capture latency becomes 8*(SETTLE_CYCLES+2).
- Undefined: dut_out is sampled directly, with the timing of REQ-015/REQ-017.
- Bit ordering and handshake are identical in both builds.

Verification
REQ-025 SETTLE_CYCLES=4, combinational model of rows 001/101/111 = 1, start pulse -> rule_valid at cycle 32, rule_code=0x45, drv sequence 000..111 with 4 cycles per step.
REQ-026 Model out=in1 XOR in2 XOR in3, rule_ready held low 10 cycles then high -> rule_code=0x69 stable all 10 cycles; rule_valid drops one cycle after ready; state returns to IDLE.
REQ-027 Constant-0 model then constant-1 model, back-to-back captures -> 0x00 then 0xFF; rule_code cleared to 0x00 at the second start.
REQ-028 abort asserted during vector 3 -> drv=000 next cycle, busy=0, rule_valid never asserts; a following start produces the full correct code.
REQ-029 rst_n pulsed low during vector 5 -> all outputs at reset values asynchronously; start re-pulsed during DRIVE and HOLD -> ignored.
REQ-030 TTC_SYNC_EN defined, SETTLE_CYCLES=4, 0x45 model -> rule_valid at cycle 48, rule_code=0x45.

Source files
------------

// File: rtl/truth_table_capture.sv
// Sweeps a 3-input circuit through all eight input rows and records its output as an 8-bit rule code.
// Define TTC_SYNC_EN to pass dut_out through a 2-flop synchronizer; each vector is then held two cycles longer.
module truth_table_capture #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  output logic       busy,
  output logic [7:0] rule_code,
  output logic       rule_valid,
  input  logic       rule_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

`ifdef TTC_SYNC_EN
  localparam int HOLD_CYC = SETTLE_CYCLES + 2;
`else
  localparam int HOLD_CYC = SETTLE_CYCLES;
`endif
  localparam logic [8:0] RELOAD = 9'(HOLD_CYC - 1);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("truth_table_capture: SETTLE_CYCLES must be within 1..255");
    end
  endgenerate

  logic [1:0] state;
  logic [2:0] idx;
  logic [8:0] cnt;
  logic [2:0] drv;
  logic       sample;

`ifdef TTC_SYNC_EN
  logic [1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], dut_out};
    end
  end

  assign sample = sync_ff[1];
`else
  assign sample = dut_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cnt       <= 9'd0;
      drv       <= 3'b000;
      rule_code <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            idx       <= 3'd0;
            cnt       <= RELOAD;
            drv       <= 3'b000;
            rule_code <= 8'h00;
          end
        end
        DRIVE: begin
          // abort wins even over the final-vector sample; the partial code is kept
          if (abort) begin
            state <= IDLE;
            idx   <= 3'd0;
            cnt   <= 9'd0;
            drv   <= 3'b000;
          end else if (cnt == 9'd0) begin
            rule_code[3'd7 - idx] <= sample;
            idx <= idx + 3'd1;
            cnt <= RELOAD;
            if (idx == 3'd7) begin
              state <= HOLD;
              drv   <= 3'b111;
            end else begin
              drv <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 9'd1;
          end
        end
        HOLD: begin
          if (rule_ready) begin
            state <= IDLE;
            idx   <= 3'd0;
            drv   <= 3'b000;
          end
        end
        default: begin
          state <= IDLE;
          drv   <= 3'b000;
        end
      endcase
    end
  end

  assign {drv_in1, drv_in2, drv_in3} = drv;
  assign busy       = (state == DRIVE);
  assign rule_valid = (state == HOLD);

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: capture, stall, back-to-back, abort and mid-capture reset.
module tb_truth_table_capture;

  localparam int S = 4;
`ifdef TTC_SYNC_EN
  localparam int LAT = 8 * (S + 2);
`else
  localparam int LAT = 8 * S;
`endif
  localparam int VH = LAT / 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       rule_ready = 1'b0;
  logic       dut_out;
  logic       drv_in1, drv_in2, drv_in3;
  logic       busy, rule_valid;
  logic [7:0] rule_code;
  logic [2:0] drv;
  int         model_sel = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  truth_table_capture #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
    .drv_in1(drv_in1), .drv_in2(drv_in2), .drv_in3(drv_in3), .busy(busy),
    .rule_code(rule_code), .rule_valid(rule_valid), .rule_ready(rule_ready)
  );

  always #5 clk = ~clk;
  assign drv = {drv_in1, drv_in2, drv_in3};

  // Circuit under characterization: 0 = rows 001/101/111, 1 = 3-way XOR, 2 = const 0, 3 = const 1
  always_comb begin
    dut_out = 1'b0;
    case (model_sel)
      0: dut_out = (~drv_in1 & ~drv_in2 & drv_in3) | (drv_in1 & ~drv_in2 & drv_in3) | (drv_in1 & drv_in2 & drv_in3);
      1: dut_out = drv_in1 ^ drv_in2 ^ drv_in3;
      2: dut_out = 1'b0;
      default: dut_out = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (rule_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic handshake();
    rule_ready = 1'b1;
    tick();
    rule_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, rule_valid, drv, rule_code} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b valid=%b drv=%b code=%h, required all zero", busy, rule_valid, drv, rule_code);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({busy, rule_valid, drv} !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_release_idle: busy=%b valid=%b drv=%b, required 0/0/000", busy, rule_valid, drv);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int lat;
    int drv_err = 0;
    model_sel = 0;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy: busy=%b, required 1", busy);
    end
    for (int k = 0; k < LAT; k++) begin
      if (k > 0) tick();
      // start re-pulse mid-DRIVE must not restart the sweep
      start = (k == 10);
      n_cmp++;
      if (drv !== 3'(k / VH) || rule_valid !== 1'b0) begin
        n_bad++; drv_err++;
        $display("FAIL basic_drv_seq: cycle %0d drv=%b valid=%b, required drv=%b valid=0", k, drv, rule_valid, 3'(k / VH));
      end
    end
    start = 1'b0;
    tick();
    n_cmp++;
    if (rule_valid !== 1'b1 || rule_code !== 8'h45 || drv !== 3'b111) begin
      n_bad++;
      $display("FAIL basic_result: valid=%b code=%h drv=%b at cycle %0d, required 1/45/111", rule_valid, rule_code, drv, LAT);
    end
    lat = 0;
    pulse_start();
    n_cmp++;
    if (rule_valid !== 1'b1 || busy !== 1'b0 || rule_code !== 8'h45) begin
      n_bad++;
      $display("FAIL hold_ignores_start: valid=%b busy=%b code=%h, required 1/0/45", rule_valid, busy, rule_code);
    end
    handshake();
    n_cmp++;
    if (rule_valid !== 1'b0 || busy !== 1'b0 || drv !== 3'b000) begin
      n_bad++;
      $display("FAIL basic_release: valid=%b busy=%b drv=%b, required 0/0/000", rule_valid, busy, drv);
    end
    $display("test_basic done: code=%h drv_errors=%0d", rule_code, drv_err + lat);
  endtask

  task automatic test_ready_stall();
    int lat;
    model_sel = 1;
    pulse_start();
    wait_valid(lat);
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++;
      $display("FAIL stall_latency: %0d cycles, required %0d", lat, LAT);
    end
    for (int k = 0; k < 10; k++) begin
      abort = (k == 3);
      tick();
      n_cmp++;
      if (rule_valid !== 1'b1 || rule_code !== 8'h69 || drv !== 3'b111) begin
        n_bad++;
        $display("FAIL stall_hold: cycle %0d valid=%b code=%h drv=%b, required 1/69/111", k, rule_valid, rule_code, drv);
      end
    end
    abort = 1'b0;
    start = 1'b1;
    handshake();
    start = 1'b0;
    n_cmp++;
    if (rule_valid !== 1'b0 || busy !== 1'b0 || rule_code !== 8'h69) begin
      n_bad++;
      $display("FAIL stall_release: valid=%b busy=%b code=%h, required 0/0/69", rule_valid, busy, rule_code);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || drv !== 3'b000) begin
      n_bad++;
      $display("FAIL handshake_start_ignored: busy=%b drv=%b, required 0/000", busy, drv);
    end
    $display("test_ready_stall done: code=%h", rule_code);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] exp_code [3] = '{8'h00, 8'hFF, 8'h00};
    int         sel [3]      = '{2, 3, 2};
    for (int i = 0; i < 3; i++) begin
      model_sel = sel[i];
      pulse_start();
      n_cmp++;
      if (rule_code !== 8'h00 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_clear_%0d: code=%h busy=%b, required 00/1", i, rule_code, busy);
      end
      wait_valid(lat);
      n_cmp++;
      if (lat !== LAT || rule_code !== exp_code[i]) begin
        n_bad++;
        $display("FAIL b2b_capture_%0d: lat=%0d code=%h, required %0d/%h", i, lat, rule_code, LAT, exp_code[i]);
      end
      handshake();
      $display("test_back_to_back capture %0d: code=%h", i, rule_code);
    end
  endtask

  task automatic test_abort();
    int lat;
    model_sel = 0;
    pulse_start();
    for (int k = 1; k <= 3 * VH + 1; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (drv !== 3'b000 || busy !== 1'b0 || rule_valid !== 1'b0 || rule_code !== 8'h40) begin
      n_bad++;
      $display("FAIL abort_state: drv=%b busy=%b valid=%b code=%h, required 000/0/0/40", drv, busy, rule_valid, rule_code);
    end
    wait_valid(lat);
    n_cmp++;
    if (lat !== -1) begin
      n_bad++;
      $display("FAIL abort_no_valid: valid rose after %0d cycles, required never", lat);
    end
    pulse_start();
    wait_valid(lat);
    n_cmp++;
    if (lat !== LAT || rule_code !== 8'h45) begin
      n_bad++;
      $display("FAIL abort_recapture: lat=%0d code=%h, required %0d/45", lat, rule_code, LAT);
    end
    handshake();
    $display("test_abort done: code=%h", rule_code);
  endtask

  task automatic test_reset_mid();
    int lat;
    model_sel = 0;
    pulse_start();
    for (int k = 1; k <= 5 * VH + 1; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, rule_valid, drv, rule_code} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_async: busy=%b valid=%b drv=%b code=%h, required all zero", busy, rule_valid, drv, rule_code);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_valid(lat);
    n_cmp++;
    if (lat !== LAT || rule_code !== 8'h45) begin
      n_bad++;
      $display("FAIL reset_recapture: lat=%0d code=%h, required %0d/45", lat, rule_code, LAT);
    end
    handshake();
    $display("test_reset_mid done: code=%h", rule_code);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_stall();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
